// File: rtl/j80_pkg.sv
// Shared constants and types for the i8080 bus front end and LCD8080Ctrl.
package j80_pkg;

  localparam logic [7:0] PIX_CMD_DEFAULT = 8'h2C;
  localparam logic [7:0] CMD_DISPLAY_ON  = 8'h29;
  localparam logic [7:0] CMD_DISPLAY_OFF = 8'h28;
  localparam logic [7:0] CMD_BACKLIGHT   = 8'h51;

  typedef struct packed {
    logic       cs;
    logic       rs;
    logic       we;
    logic [7:0] data;
  } j80_bus_t;

  localparam j80_bus_t BUS_IDLE = '{cs: 1'b1, rs: 1'b0, we: 1'b0, data: 8'h00};

  function automatic logic [15:0] pack_pixel(input logic [7:0] first,
                                             input logic [7:0] second,
                                             input bit msb_first);
    return msb_first ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/j80_sync_filter.sv
// Synchronizes the asynchronous 8080 bus pins and turns each qualified
// falling edge of the write strobe into a single-cycle write event.
module j80_sync_filter
  import j80_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WE_HIGH = 1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       cs_n,
  input  logic       rs,
  input  logic       we,
  input  logic [7:0] data,
  output logic       wr_evt,
  output logic       wr_rs,
  output logic [7:0] wr_byte
);

  localparam int CNT_W = (MIN_WE_HIGH < 2) ? 1 : $clog2(MIN_WE_HIGH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_WE_HIGH);

  j80_bus_t [SYNC_STAGES-1:0] sync_q, sync_d;
  j80_bus_t                   hist_q, hist_d;
  j80_bus_t                   pins, cur;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  assign pins = '{cs: cs_n, rs: rs, we: we, data: data};
  assign cur  = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pins};
    hist_d = cur;
    cnt_d  = '0;
    if (cur.we && !cur.cs) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync_q <= {SYNC_STAGES{BUS_IDLE}};
      hist_q <= BUS_IDLE;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

  // RS/data come from the history stage: the last sample taken with We high.
  assign wr_evt  = hist_q.we && !hist_q.cs && !cur.we && !cur.cs && (cnt_q >= CNT_MAX);
  assign wr_rs   = hist_q.rs;
  assign wr_byte = hist_q.data;

endmodule

// File: rtl/j80_bus_frontend.sv
// i8080 bus front end: command/parameter decode and RGB565 pixel packing
// onto a one-entry valid/ready output register.
module j80_bus_frontend
  import j80_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         MIN_WE_HIGH = 1,
  parameter logic [7:0] PIX_CMD     = PIX_CMD_DEFAULT,
  parameter bit         MSB_FIRST   = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        J80_CS,
  input  logic        J80_RS,
  input  logic        J80_We,
  input  logic [7:0]  J80_Data,
  output logic        CmdValid,
  output logic [7:0]  CmdByte,
  output logic        ParValid,
  output logic [7:0]  ParByte,
  output logic        PixValid,
  output logic [15:0] PixData,
  input  logic        PixReady,
  output logic        PixMode,
  output logic        Overrun
);

  logic       wr_evt, wr_rs;
  logic [7:0] wr_byte;

  j80_sync_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_WE_HIGH(MIN_WE_HIGH)
  ) u_sync_filter (
    .clk    (CLK),
    .nrst   (nRST),
    .cs_n   (J80_CS),
    .rs     (J80_RS),
    .we     (J80_We),
    .data   (J80_Data),
    .wr_evt (wr_evt),
    .wr_rs  (wr_rs),
    .wr_byte(wr_byte)
  );

  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic        par_valid_q, par_valid_d;
  logic [7:0]  par_byte_q, par_byte_d;
  logic        pix_valid_q, pix_valid_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic        pix_mode_q, pix_mode_d;
  logic        phase_q, phase_d;
  logic [7:0]  half_q, half_d;
  logic        overrun_q, overrun_d;
  logic        new_pix;

  always_comb begin
    cmd_valid_d = 1'b0;
    cmd_byte_d  = cmd_byte_q;
    par_valid_d = 1'b0;
    par_byte_d  = par_byte_q;
    pix_valid_d = pix_valid_q;
    pix_data_d  = pix_data_q;
    pix_mode_d  = pix_mode_q;
    phase_d     = phase_q;
    half_d      = half_q;
    overrun_d   = overrun_q;
    new_pix     = 1'b0;

    if (wr_evt) begin
      if (!wr_rs) begin
        cmd_valid_d = 1'b1;
        cmd_byte_d  = wr_byte;
        pix_mode_d  = (wr_byte == PIX_CMD);
        phase_d     = 1'b0;
        if (phase_q) overrun_d = 1'b1;
      end else if (!pix_mode_q) begin
        par_valid_d = 1'b1;
        par_byte_d  = wr_byte;
      end else if (!phase_q) begin
        half_d  = wr_byte;
        phase_d = 1'b1;
      end else begin
        new_pix = 1'b1;
        phase_d = 1'b0;
      end
    end

    // A full register that is not being drained this cycle drops the new pixel.
    if (new_pix) begin
      if (!pix_valid_q || PixReady) begin
        pix_valid_d = 1'b1;
        pix_data_d  = pack_pixel(half_q, wr_byte, MSB_FIRST);
      end else begin
        overrun_d = 1'b1;
      end
    end else if (pix_valid_q && PixReady) begin
      pix_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= '0;
      par_valid_q <= 1'b0;
      par_byte_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_mode_q  <= 1'b0;
      phase_q     <= 1'b0;
      half_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
      par_valid_q <= par_valid_d;
      par_byte_q  <= par_byte_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      pix_mode_q  <= pix_mode_d;
      phase_q     <= phase_d;
      half_q      <= half_d;
      overrun_q   <= overrun_d;
    end
  end

  assign CmdValid = cmd_valid_q;
  assign CmdByte  = cmd_byte_q;
  assign ParValid = par_valid_q;
  assign ParByte  = par_byte_q;
  assign PixValid = pix_valid_q;
  assign PixData  = pix_data_q;
  assign PixMode  = pix_mode_q;
  assign Overrun  = overrun_q;

endmodule
